// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first.
// One full-subtractor cell; start/busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;

  logic a_bit, b_bit;
  logic diff_bit, borrow_nxt;

  assign a_bit      = a_sh_q[0];
  assign b_bit      = b_sh_q[0];
  assign diff_bit   = a_bit ^ b_bit ^ br_q;
  assign borrow_nxt = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    r_sh_d  = r_sh_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = A;
          b_sh_d  = B;
          br_d    = Bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        r_sh_d = {diff_bit, r_sh_q[WIDTH-1:1]};
        br_d   = borrow_nxt;
        cnt_d  = cnt_q + 1'b1;
        // last bit: publish the full result including this bit
        if (cnt_q == LAST) begin
          d_d     = {diff_bit, r_sh_q[WIDTH-1:1]};
          bout_d  = borrow_nxt;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      r_sh_q  <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      r_sh_q  <= r_sh_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = done_q;
  assign D    = d_q;
  assign Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor, WIDTH=4 and WIDTH=8.
module tb_serial_subtractor;

  logic       clock = 1'b0;
  logic       reset = 1'b1;

  logic       start4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       bin4 = 1'b0;
  logic       busy4, done4, bout4;
  logic [3:0] d4;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0;
  logic       busy8, done8, bout8;
  logic [7:0] d8;

  int vecs = 0;
  int errs = 0;

  always #5 clock = ~clock;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clock(clock), .reset(reset), .start(start4),
    .A(a4), .B(b4), .Bin(bin4),
    .busy(busy4), .done(done4), .D(d4), .Bout(bout4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clock(clock), .reset(reset), .start(start8),
    .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .D(d8), .Bout(bout8)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    vecs++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // one complete operation; inputs driven and outputs sampled on negedges
  task automatic op(input bit w8, input int a, input int b,
                    input bit bin, input int ed, input int eb);
    int n;
    int w;
    w = w8 ? 8 : 4;
    @(negedge clock);
    if (w8) begin
      start8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; bin8 = bin;
    end else begin
      start4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; bin4 = bin;
    end
    @(negedge clock);
    start4 = 1'b0;
    start8 = 1'b0;
    chk("busy_after_start", w8 ? busy8 : busy4, 1);
    n = 0;
    while (n < w + 4) begin
      @(negedge clock);
      n++;
      if (w8 ? done8 : done4) break;
      chk("busy_mid", w8 ? busy8 : busy4, 1);
    end
    chk("latency", n, w);
    chk("D", w8 ? int'(d8) : int'(d4), ed);
    chk("Bout", w8 ? bout8 : bout4, eb);
    chk("busy_at_done", w8 ? busy8 : busy4, 0);
    @(negedge clock);
    chk("done_one_cycle", w8 ? done8 : done4, 0);
    chk("D_hold", w8 ? int'(d8) : int'(d4), ed);
  endtask

  initial begin
    int n;
    int pulses;

    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_D", d4, 0);
    chk("rst_Bout", bout4, 0);
    chk("rst_D8", d8, 0);

    op(1'b0, 9, 3, 1'b0, 6, 0);
    op(1'b0, 3, 5, 1'b0, 14, 1);
    op(1'b0, 0, 0, 1'b1, 15, 1);
    op(1'b0, 15, 15, 1'b0, 0, 0);

    // start during busy and operand changes are ignored
    @(negedge clock);
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd3; bin4 = 1'b0;
    @(negedge clock);
    start4 = 1'b0; a4 = 4'd0; b4 = 4'd0;
    @(negedge clock);
    start4 = 1'b1; a4 = 4'd1; b4 = 4'd1; bin4 = 1'b1;
    @(negedge clock);
    start4 = 1'b0; a4 = 4'd15; b4 = 4'd7; bin4 = 1'b0;
    n = 2;
    while (n < 10) begin
      @(negedge clock);
      n++;
      if (done4) break;
    end
    chk("ign_latency", n, 4);
    chk("ign_D", d4, 6);
    chk("ign_Bout", bout4, 0);
    repeat (3) @(negedge clock);
    chk("ign_busy_idle", busy4, 0);
    chk("ign_done_low", done4, 0);
    chk("ign_D_hold", d4, 6);

    // back-to-back with start held high
    @(negedge clock);
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0;
    @(negedge clock);
    n = 0;
    pulses = 0;
    while (n < 14) begin
      @(negedge clock);
      n++;
      if (done4) begin
        pulses++;
        if (pulses == 1) begin
          chk("b2b_first_at", n, 4);
          chk("b2b_D1", d4, 5);
          chk("b2b_Bout1", bout4, 0);
          a4 = 4'd2; b4 = 4'd7;
        end else begin
          chk("b2b_second_at", n, 9);
          chk("b2b_D2", d4, 11);
          chk("b2b_Bout2", bout4, 1);
          start4 = 1'b0;
          break;
        end
      end else if (n == 5) begin
        chk("b2b_busy_gap", busy4, 1);
        chk("b2b_D1_hold", d4, 5);
      end
    end
    chk("b2b_pulses", pulses, 2);
    start4 = 1'b0;
    repeat (6) @(negedge clock);

    // reset mid-operation
    op(1'b0, 9, 3, 1'b0, 6, 0);
    @(negedge clock);
    start4 = 1'b1; a4 = 4'd5; b4 = 4'd1;
    @(negedge clock);
    start4 = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rmid_busy", busy4, 0);
    chk("rmid_done", done4, 0);
    chk("rmid_D", d4, 0);
    chk("rmid_Bout", bout4, 0);
    pulses = 0;
    repeat (8) begin
      @(negedge clock);
      if (done4) pulses++;
    end
    chk("rmid_no_done", pulses, 0);

    // reset wins over start
    @(negedge clock);
    reset = 1'b1; start4 = 1'b1; a4 = 4'd9; b4 = 4'd3;
    @(negedge clock);
    reset = 1'b0; start4 = 1'b0;
    chk("rst_over_start", busy4, 0);

    op(1'b1, 200, 55, 1'b0, 145, 0);
    op(1'b1, 10, 20, 1'b1, 245, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement subtractor: computes D = A - B - Bin one bit per clock, LSB first, with a single full-subtractor cell and shift registers.
- Inverse-operation companion to the combinational ripple-carry adder datapath. It trades latency for area and is driven by a start/busy/done handshake.
- Operands come from the board switch datapath; results drive LEDR alongside the adder result.

Parameters:
- WIDTH, 4, operand and result width in bits (WIDTH >= 2).

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous reset, active-high.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when D/Bout are updated.
- D  output  WIDTH  difference, registered, held between operations.
- Bout  output  1  borrow-out (1 when A < B + Bin, unsigned), registered, held.

Behaviour:
- One clock domain. Reset is synchronous and active-high on port reset. Clock port is clock.
- Reset values:
  - busy=0, done=0, D=0, Bout=0.
  - Internal state=IDLE, shift registers=0, borrow register=0, bit counter=0.
- States:
  - IDLE: busy=0. Waiting for start.
  - SHIFT: busy=1. Processing one bit per cycle.
- IDLE, start=1 at edge 0:
  - Latch A, B and Bin into the operand shift registers and the borrow register.
  - Counter=0. Go to SHIFT, so busy=1 after edge 0.
- SHIFT, each edge:
  - Take a=A_sh[0], b=B_sh[0], br=borrow register.
  - Compute diff bit = a^b^br.
  - Compute next borrow = (~a&b) | (~a&br) | (b&br).
  - Shift the diff bit into the MSB of the result shift register. Shift A_sh and B_sh right by one.
  - Increment the counter.
- Bits are processed at edges 1..WIDTH.
- At edge WIDTH (counter == WIDTH-1 before the edge):
  - Load D with the full result including the current bit. Load Bout with the next borrow.
  - done=1, busy=0, return to IDLE.
- Latency: start accepted at edge 0, so done=1 and D/Bout valid after edge WIDTH (WIDTH cycles).
- done is high for exactly one cycle. It deasserts at the next edge unless a new operation completes there, which is impossible for WIDTH >= 2.
- D and Bout change only at the completion edge. They hold their value through subsequent operations until the next completion.
- start while busy=1 is ignored. The operation in flight and its latched operands are unaffected.
- A, B and Bin are don't-care except at the accepting edge. Changing them mid-operation has no effect.
- start=1 in the done cycle is accepted, since busy=0: back-to-back operation with no idle gap.
- start held high continuously: a new operation starts every WIDTH+1 edges.
- Arithmetic is modulo 2^WIDTH. {Bout, D} equals the (WIDTH+1)-bit result A - B - Bin, and Bout is the sign/borrow.
- Reset mid-operation (reset=1 in SHIFT):
  - Return to IDLE; all outputs go to reset values, including clearing D and Bout.
  - No done pulse. The aborted operation is lost.
- Reset has priority over start in the same cycle.

Test Plan:
- WIDTH=4, A=9, B=3, Bin=0, start 1 cycle -> busy=1 for edges 1..3; done pulse after edge 4; D=6, Bout=0.
- WIDTH=4, A=3, B=5, Bin=0 -> D=14 (4'b1110), Bout=1. A=0, B=0, Bin=1 -> D=15, Bout=1. A=15, B=15, Bin=0 -> D=0, Bout=0.
- Start 9-3; pulse start with A=1, B=1 at edge 2 (busy) and change A/B mid-op -> ignored; done after edge 4 with D=6, Bout=0; D holds 6 until the next completion.
- Back-to-back: start=1 held; first op 7-2, second op 2-7 presented in the done cycle -> D=5/Bout=0, then exactly 5 edges later D=11/Bout=1, each with a single done pulse.
- Run 9-3 to completion (D=6), then start 5-1 and assert reset at edge 2 -> next cycle busy=0, done=0, D=0, Bout=0; no done pulse within the following 8 cycles.
- WIDTH=8: A=200, B=55, Bin=0 -> done after edge 8, D=145, Bout=0. A=10, B=20, Bin=1 -> D=245, Bout=1.
